buscar_asignar_seq: RTL and testbench
=====================================

Name: buscar_asignar_seq

Overview:
Parametrised, sequential successor to the combinational search-and-assign block of Lab 4. It holds an internal ROWS x COLS matrix of DATA_W-bit cells. On a start request it scans the matrix one cell per clock for a key. Depending on mode, it reports only, replaces the first match, or replaces every match. Results are reported through a start/busy/done handshake, and a host-side write/read port loads and inspects the matrix between scans.

Parameters:
ROWS, 8, matrix row count (>=1)
COLS, 8, matrix column count (>=1)
DATA_W, 10, cell width in bits
KEY_W, 6, search key width (KEY_W <= DATA_W)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  host cell write; honoured only in IDLE
wr_row  in  $clog2(ROWS)  write row index
wr_col  in  $clog2(COLS)  write column index
wr_data  in  DATA_W  write data
rd_row  in  $clog2(ROWS)  read row index
rd_col  in  $clog2(COLS)  read column index
rd_data  out  DATA_W  combinational read of cell[rd_row][rd_col]
start  in  1  scan request; sampled only in IDLE
key  in  KEY_W  search key; captured on accepted start
mode  in  2  0=SEARCH, 1=REPLACE_FIRST, 2=REPLACE_ALL, 3=reserved (treated as SEARCH); captured on start
assign_val  in  DATA_W  replacement value; captured on start
busy  out  1  high in SCAN
done  out  1  one-cycle pulse when a scan completes
found  out  1  at least one match in the last scan
match_count  out  $clog2(ROWS*COLS+1)  matches seen in the last scan
first_row  out  $clog2(ROWS)  row of the first match (row-major order)
first_col  out  $clog2(COLS)  column of the first match

Behaviour:
- Reset, synchronous: all cells=0, FSM=IDLE, and busy, done, found, match_count, first_row, first_col all 0. Reset mid-scan aborts the scan with no further writes and no done pulse.
- FSM states and transitions:
  - IDLE -> SCAN on start=1: capture key, mode and assign_val; clear found, match_count and the first_* outputs; zero the scan index.
  - SCAN: examine one cell per cycle in row-major order, (0,0),(0,1)…(ROWS-1,COLS-1).
  - SCAN -> DONE after the last cell, or right after the first match when mode=REPLACE_FIRST.
  - DONE -> IDLE unconditionally. done=1 only in DONE.
- Match rule: the cell equals the zero-extended key, i.e. upper DATA_W-KEY_W bits are 0 and the lower KEY_W bits equal the key.
- On a match:
  - match_count increments.
  - On the first match: found=1 and first_row/first_col are latched.
  - In REPLACE modes the cell is written with assign_val in the same cycle. The written value is not re-examined during this scan, even if assign_val itself matches.
- Latency:
  - Full scan: start accepted at cycle T, busy=1 during T+1..T+ROWS*COLS, done at T+ROWS*COLS+1.
  - REPLACE_FIRST matching at scan index k: done at T+k+2.
- Results hold their values until the next accepted start or reset.
- Boundaries:
  - start while in SCAN or DONE is ignored. start and wr_en together in IDLE: the write is performed and the start is accepted; the scan sees the written value.
  - wr_en outside IDLE is dropped silently.
  - Out-of-range indices (non-power-of-two ROWS/COLS): writes are ignored, reads return 0.
  - match_count saturates at ROWS*COLS. No wrap is possible given its width.
  - rd_data reflects in-scan replacements from the cycle after the write.

Decomposition:
- Package buscar_pkg holds:
  - typedef enum of the FSM states (IDLE, SCAN, DONE);
  - typedef enum of the mode encodings;
  - a localparam function deriving the index widths.
- One sub-module: buscar_scan_idx. It is a row/column counter with enable, clear and a last-cell flag, and it keeps the row-major wrap logic out of the FSM.

Test Plan:
- Reset, then read all 64 cells -> every rd_data=0; busy=0, done=0, found=0.
- Load cell[i][j]=(i*8+j)%64, start key=37 mode=SEARCH -> done at T+65, found=1, match_count=1, first=(4,5), matrix unchanged.
- Load all cells 10'd5 except cell[2][3]=10'd69 (upper bits set), start key=5 mode=REPLACE_ALL assign_val=10'h3FF -> match_count=63, cell[2][3] stays 69, every other cell reads 3FF.
- Cells (1,1) and (6,6)=12, others 0, start key=12 mode=REPLACE_FIRST assign_val=7 -> done at T+11, first=(1,1), match_count=1, (1,1)=7, (6,6)=12.
- Start key=63 with no 63 present -> found=0, match_count=0, done at T+65; start pulses and wr_en during SCAN are ignored (cell unchanged, no restart).
- Assert rst at scan cycle 20 of a REPLACE_ALL -> next cycle busy=0, no done pulse, all cells 0; a fresh start then completes normally.

Source files
------------

// File: rtl/buscar_pkg.sv
// Shared types and width helper for the sequential search-and-assign block.
package buscar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_SEARCH        = 2'd0,
        MODE_REPLACE_FIRST = 2'd1,
        MODE_REPLACE_ALL   = 2'd2,
        MODE_RESERVED      = 2'd3
    } mode_t;

    // Index width for an n-entry dimension; a single-entry dimension still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buscar_scan_idx.sv
// Row-major row/column scan counter with clear, enable and a last-cell flag.
module buscar_scan_idx
    import buscar_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW  = idx_w(ROWS),
    localparam int CW  = idx_w(COLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    assign last = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/buscar_asignar_seq.sv
// Sequential search-and-assign over a ROWS x COLS matrix, one cell per clock.
// Handshake: start is taken only in IDLE; busy is high while scanning; done pulses for one cycle.
module buscar_asignar_seq
    import buscar_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 10,
    parameter int KEY_W  = 6,
    localparam int RW    = idx_w(ROWS),
    localparam int CW    = idx_w(COLS),
    localparam int MW    = $clog2(ROWS * COLS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_row,
    input  logic [CW-1:0]     wr_col,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [RW-1:0]     rd_row,
    input  logic [CW-1:0]     rd_col,
    output logic [DATA_W-1:0] rd_data,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] assign_val,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [MW-1:0]     match_count,
    output logic [RW-1:0]     first_row,
    output logic [CW-1:0]     first_col,
    output state_t            state_dbg
);

    localparam logic [MW-1:0] COUNT_MAX = MW'(ROWS * COLS);

    state_t              state, state_nxt;
    logic [KEY_W-1:0]    key_q;
    mode_t               mode_q;
    logic [DATA_W-1:0]   aval_q;
    logic [DATA_W-1:0]   cells [ROWS][COLS];
    logic [RW-1:0]       scan_row;
    logic [CW-1:0]       scan_col;
    logic                scan_last;
    logic                accept, hit, replace_en, wr_ok, stop_first;

    assign accept     = (state == IDLE) && start;
    assign hit        = (state == SCAN) && (cells[scan_row][scan_col] == DATA_W'(key_q));
    assign replace_en = (mode_q == MODE_REPLACE_FIRST) || (mode_q == MODE_REPLACE_ALL);
    assign stop_first = hit && (mode_q == MODE_REPLACE_FIRST);
    assign wr_ok      = (state == IDLE) && wr_en && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

    assign busy      = (state == SCAN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    buscar_scan_idx #(.ROWS(ROWS), .COLS(COLS)) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (state == SCAN),
        .row  (scan_row),
        .col  (scan_col),
        .last (scan_last)
    );

    always_comb begin
        rd_data = '0;
        if ((32'(rd_row) < ROWS) && (32'(rd_col) < COLS)) begin
            rd_data = cells[rd_row][rd_col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (scan_last || stop_first) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A host write and an accepted start can share a cycle: the write lands before the scan begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    cells[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            cells[wr_row][wr_col] <= wr_data;
        end else if (hit && replace_en) begin
            cells[scan_row][scan_col] <= aval_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            mode_q      <= MODE_SEARCH;
            aval_q      <= '0;
            found       <= 1'b0;
            match_count <= '0;
            first_row   <= '0;
            first_col   <= '0;
        end else if (accept) begin
            key_q       <= key;
            mode_q      <= mode_t'(mode);
            aval_q      <= assign_val;
            found       <= 1'b0;
            match_count <= '0;
            first_row   <= '0;
            first_col   <= '0;
        end else if (hit) begin
            if (match_count != COUNT_MAX) begin
                match_count <= match_count + 1'b1;
            end
            if (!found) begin
                found     <= 1'b1;
                first_row <= scan_row;
                first_col <= scan_col;
            end
        end
    end

endmodule

// File: tb/tb_buscar_asignar_seq.sv
// Directed bench for buscar_asignar_seq: vector table of scans plus hand-written corner sequences.
module tb_buscar_asignar_seq;
    import buscar_pkg::*;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
    logic [9:0] wr_data = '0, assign_val = '0, rd_data;
    logic       start = 1'b0;
    logic [5:0] key = '0;
    logic [1:0] mode = '0;
    logic       busy, done, found;
    logic [6:0] match_count;
    logic [2:0] first_row, first_col;
    state_t     state_dbg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    buscar_asignar_seq dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .start(start), .key(key), .mode(mode), .assign_val(assign_val),
        .busy(busy), .done(done), .found(found), .match_count(match_count),
        .first_row(first_row), .first_col(first_col), .state_dbg(state_dbg)
    );

    typedef struct {
        string      name;
        logic [5:0] key;
        logic [1:0] mode;
        logic [9:0] aval;
        logic       exp_found;
        int         exp_cnt;
        int         exp_row;
        int         exp_col;
        int         exp_lat;
        int         chk_row;
        int         chk_col;
        logic [9:0] chk_val;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr_cell(input int r, input int c, input logic [9:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        wr_row = 3'(r);
        wr_col = 3'(c);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd_cell(input int r, input int c, output logic [9:0] d);
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        d = rd_data;
    endtask

    task automatic fill_all(input logic [9:0] d);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr_cell(r, c, d);
    endtask

    // Latency counts cycles after the accepting edge; done observed in cycle T+n gives n.
    task automatic run_scan(input string name, input logic [5:0] k, input logic [1:0] m,
                            input logic [9:0] av, input logic we, input int wr_r,
                            input int wr_c, input logic [9:0] wd, output int lat);
        logic busy_bad;
        busy_bad = 1'b0;
        @(negedge clk);
        start = 1'b1;
        key = k;
        mode = m;
        assign_val = av;
        wr_en = we;
        wr_row = 3'(wr_r);
        wr_col = 3'(wr_c);
        wr_data = wd;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_bad = 1'b1;
            @(negedge clk);
        end
        check({name, "_busy_held"}, 32'(busy_bad), 32'd0);
    endtask

    task automatic check_results(input string name, input int lat, input int exp_lat,
                                 input logic exp_found, input int exp_cnt,
                                 input int exp_row, input int exp_col);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_found"}, 32'(found), 32'(exp_found));
        check({name, "_count"}, 32'(match_count), exp_cnt);
        check({name, "_first_row"}, 32'(first_row), exp_row);
        check({name, "_first_col"}, 32'(first_col), exp_col);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         bad;
        int         mism;
        logic [9:0] d;
        logic       seen_done;

        vecs[0] = '{"search37",   6'd37, 2'd0, 10'd0,   1'b1, 1, 4, 5, 65, 4, 5, 10'd37};
        vecs[1] = '{"search0",    6'd0,  2'd0, 10'd0,   1'b1, 1, 0, 0, 65, 0, 0, 10'd0};
        vecs[2] = '{"search63",   6'd63, 2'd0, 10'd0,   1'b1, 1, 7, 7, 65, 7, 7, 10'd63};
        vecs[3] = '{"reserved10", 6'd10, 2'd3, 10'd1,   1'b1, 1, 1, 2, 65, 1, 2, 10'd10};
        vecs[4] = '{"rfirst20",   6'd20, 2'd1, 10'd900, 1'b1, 1, 2, 4, 22, 2, 4, 10'd900};
        vecs[5] = '{"search20",   6'd20, 2'd0, 10'd0,   1'b0, 0, 0, 0, 65, 2, 4, 10'd900};
        vecs[6] = '{"rall1",      6'd1,  2'd2, 10'd2,   1'b1, 1, 0, 1, 65, 0, 1, 10'd2};
        vecs[7] = '{"search2",    6'd2,  2'd0, 10'd0,   1'b1, 2, 0, 1, 65, 0, 2, 10'd2};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_count", 32'(match_count), 32'd0);
        check("rst_first_row", 32'(first_row), 32'd0);
        check("rst_first_col", 32'(first_col), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_cell(r, c, d);
                if (d != 10'd0) bad++;
            end
        check("rst_cells_nonzero", bad, 0);

        // Vector table on the index matrix cell[i][j] = i*8+j
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                wr_cell(r, c, 10'((r * 8 + c) % 64));
        for (int i = 0; i < 8; i++) begin
            run_scan(vecs[i].name, vecs[i].key, vecs[i].mode, vecs[i].aval, 1'b0, 0, 0, 10'd0, lat);
            check_results(vecs[i].name, lat, vecs[i].exp_lat, vecs[i].exp_found,
                          vecs[i].exp_cnt, vecs[i].exp_row, vecs[i].exp_col);
            rd_cell(vecs[i].chk_row, vecs[i].chk_col, d);
            check({vecs[i].name, "_cell"}, 32'(d), 32'(vecs[i].chk_val));
        end
        mism = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_cell(r, c, d);
                if (r == 2 && c == 4) begin
                    if (d != 10'd900) mism++;
                end else if (r == 0 && c == 1) begin
                    if (d != 10'd2) mism++;
                end else if (d != 10'(r * 8 + c)) begin
                    mism++;
                end
            end
        check("table_matrix_cells_wrong", mism, 0);

        // REPLACE_ALL with an upper-bit cell that must not match
        fill_all(10'd5);
        wr_cell(2, 3, 10'd69);
        run_scan("rall_upper", 6'd5, 2'd2, 10'h3FF, 1'b0, 0, 0, 10'd0, lat);
        check_results("rall_upper", lat, 65, 1'b1, 63, 0, 0);
        mism = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_cell(r, c, d);
                if (d != ((r == 2 && c == 3) ? 10'd69 : 10'h3FF)) mism++;
            end
        check("rall_upper_cells_wrong", mism, 0);

        // REPLACE_FIRST stops right after the first match
        fill_all(10'd0);
        wr_cell(1, 1, 10'd12);
        wr_cell(6, 6, 10'd12);
        run_scan("rfirst12", 6'd12, 2'd1, 10'd7, 1'b0, 0, 0, 10'd0, lat);
        check_results("rfirst12", lat, 11, 1'b1, 1, 1, 1);
        rd_cell(1, 1, d);
        check("rfirst12_cell11", 32'(d), 32'd7);
        rd_cell(6, 6, d);
        check("rfirst12_cell66", 32'(d), 32'd12);

        // All cells match and assign_val also matches: count tops out at 64, no re-examination
        wr_cell(1, 1, 10'd0);
        wr_cell(6, 6, 10'd0);
        run_scan("rall_sat", 6'd0, 2'd2, 10'd0, 1'b0, 0, 0, 10'd0, lat);
        check_results("rall_sat", lat, 65, 1'b1, 64, 0, 0);

        // No match; start and wr_en during SCAN and start during DONE are ignored
        @(negedge clk);
        start = 1'b1;
        key = 6'd63;
        mode = 2'd0;
        assign_val = 10'd0;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            start = (c == 5);
            wr_en = (c == 10);
            wr_row = 3'd3;
            wr_col = 3'd3;
            wr_data = 10'd63;
            @(negedge clk);
        end
        wr_en = 1'b0;
        start = 1'b1;
        check_results("nomatch63", lat, 65, 1'b0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        check("done_start_ignored_busy", 32'(busy), 32'd0);
        check("done_start_ignored_done", 32'(done), 32'd0);
        @(negedge clk);
        check("done_start_ignored_busy2", 32'(busy), 32'd0);
        rd_cell(3, 3, d);
        check("scan_write_dropped", 32'(d), 32'd0);

        // Write and start in the same IDLE cycle: the scan sees the new value
        run_scan("wr_start", 6'd40, 2'd0, 10'd0, 1'b1, 5, 5, 10'd40, lat);
        check_results("wr_start", lat, 65, 1'b1, 1, 5, 5);

        // Reset at scan cycle 20 of a REPLACE_ALL
        @(negedge clk);
        start = 1'b1;
        key = 6'd0;
        mode = 2'd2;
        assign_val = 10'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_found", 32'(found), 32'd0);
        check("midrst_count", 32'(match_count), 32'd0);
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd_cell(r, c, d);
                if (d != 10'd0) bad++;
            end
        check("midrst_cells_nonzero", bad, 0);
        seen_done = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst_no_activity", 32'(seen_done), 32'd0);
        run_scan("after_rst", 6'd0, 2'd0, 10'd0, 1'b0, 0, 0, 10'd0, lat);
        check_results("after_rst", lat, 65, 1'b1, 64, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
